// File: rtl/bus_wait_memory.sv
// Bus-attached data memory with programmable wait states and ready handshake.
// Optional even parity per word: define BUS_MEM_PARITY_EN.
module bus_wait_memory #(
  parameter int    DATA_WIDTH    = 16,
  parameter int    ADDR_WIDTH    = 20,
  parameter int    START_ADDRESS = 0,
  parameter int    SIZE          = 1,
  parameter int    WAIT_STATES   = 1,
  parameter string INIT_FILE     = ""
) (
  input  logic                  clk,
  input  logic                  rst_n,
  inout  tri   [DATA_WIDTH-1:0] bus_data,
  input  logic [ADDR_WIDTH-1:0] bus_addr,
  input  logic                  read,
  input  logic                  write,
  output logic                  bus_ready,
  output logic                  bus_err
);

  localparam int AW = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [ADDR_WIDTH:0] LO =
    (ADDR_WIDTH+1)'(START_ADDRESS);
  localparam logic [ADDR_WIDTH:0] HI =
    (ADDR_WIDTH+1)'(START_ADDRESS + SIZE - 1);
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [3:0]            cnt_q;
  logic                  op_wr_q;
  logic [AW-1:0]         addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;

  logic [DATA_WIDTH-1:0] mem [SIZE];

  logic                  sel;
  logic [ADDR_WIDTH-1:0] off;
  logic [AW-1:0]         laddr;
  logic                  unused_off;

  assign sel = ({1'b0, bus_addr} >= LO) &&
               ({1'b0, bus_addr} <= HI);
  assign off = bus_addr - ADDR_WIDTH'(START_ADDRESS);
  assign laddr = off[AW-1:0];
  assign unused_off = ^off;

  logic                  start;
  logic                  wr_en;
  logic [AW-1:0]         wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_en;
  logic [AW-1:0]         rd_addr;

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    wr_en   = 1'b0;
    wr_addr = addr_q;
    wr_data = wdata_q;
    rd_en   = 1'b0;
    rd_addr = addr_q;
    unique case (state_q)
      IDLE: begin
        if (sel && (read ^ write)) begin
          start = 1'b1;
          if (WAIT_STATES == 0) begin
            state_d = DONE;
            wr_en   = write;
            wr_addr = laddr;
            wr_data = bus_data;
            rd_en   = read;
            rd_addr = laddr;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (!sel || !(read || write)) begin
          state_d = IDLE;
        end else if (cnt_q == 4'd1) begin
          state_d = DONE;
          wr_en   = op_wr_q;
          rd_en   = !op_wr_q;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_wr_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= (state_q == IDLE) && sel && read && write;
      if (start) begin
        cnt_q   <= WS;
        op_wr_q <= write;
        addr_q  <= laddr;
        if (write) wdata_q <= bus_data;
      end else if (state_q == BUSY) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (rd_en) rdata_q <= mem[rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign bus_ready = (state_q == DONE);
  assign bus_data  = (bus_ready && !op_wr_q) ? rdata_q : 'z;

`ifdef BUS_MEM_PARITY_EN
  logic par [SIZE];
  logic perr_q;

  always @(posedge clk) begin
    if (wr_en) par[wr_addr] <= ^wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perr_q <= 1'b0;
    end else if (rd_en) begin
      perr_q <= (^mem[rd_addr]) ^ par[rd_addr];
    end
  end

  task automatic inject_parity_flip(input logic [ADDR_WIDTH-1:0] addr);
    logic [ADDR_WIDTH-1:0] o;
    o = addr - ADDR_WIDTH'(START_ADDRESS);
    par[o[AW-1:0]] = ~par[o[AW-1:0]];
  endtask

  assign bus_err = err_q || (bus_ready && !op_wr_q && perr_q);
`else
  assign bus_err = err_q;
`endif

endmodule

// File: tb/tb_bus_wait_memory.sv
// Bench for bus_wait_memory: vector table plus abort/reset/parity sequences.
// A pull-up on bus_data makes an undriven bus read back as all ones.
module tb_bus_wait_memory;

  localparam logic [15:0] FLOAT = 16'hFFFF;
  localparam int NONE = 0;
  localparam int RDY  = 1;
  localparam int ERR  = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  tri1  [15:0] bus_data;
  logic [19:0] bus_addr;
  logic        read;
  logic        write;
  logic        bus_ready;
  logic        bus_err;
  logic        drv_en;
  logic [15:0] drv_data;

  assign bus_data = drv_en ? drv_data : 16'hzzzz;

  always #5 clk = ~clk;

  bus_wait_memory #(
    .DATA_WIDTH   (16),
    .ADDR_WIDTH   (20),
    .START_ADDRESS(32'h100),
    .SIZE         (16),
    .WAIT_STATES  (2),
    .INIT_FILE    ("")
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus_data (bus_data),
    .bus_addr (bus_addr),
    .read     (read),
    .write    (write),
    .bus_ready(bus_ready),
    .bus_err  (bus_err)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [19:0] addr;
    logic [15:0] wdata;
    int          exp;
    logic [15:0] rdata;
  } vec_t;

  typedef struct {
    int          lat;
    logic [15:0] data;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_bus();
    read   = 1'b0;
    write  = 1'b0;
    drv_en = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    exp_t e;
    int   k;
    bus_addr = v.addr;
    read     = v.rd;
    write    = v.wr;
    drv_en   = v.wr;
    drv_data = v.wdata;
    if (v.exp == RDY) begin
      e.lat  = 3;
      e.data = (v.rd && !v.wr) ? v.rdata : FLOAT;
      sbq.push_back(e);
    end
    k = 0;
    while (k < 8) begin
      @(posedge clk); #1;
      k++;
      if (bus_ready || bus_err) break;
      if (v.rd && !v.wr) chk("float_wait", bus_data, FLOAT);
    end
    idle_bus();
    #1;
    case (v.exp)
      RDY: begin
        e = sbq.pop_front();
        chk("latency", k, e.lat);
        chk("ready", bus_ready, 1);
        chk("err_on_ok", bus_err, 0);
        chk("done_data", bus_data, e.data);
      end
      ERR: begin
        chk("err_latency", k, 1);
        chk("err_pulse", bus_err, 1);
        chk("no_ready_err", bus_ready, 0);
      end
      default: begin
        chk("noresp_cycles", k, 8);
        chk("noresp_out", {bus_ready, bus_err}, 0);
      end
    endcase
    @(posedge clk); #1;
    chk("after_ready", bus_ready, 0);
    chk("after_err", bus_err, 0);
    chk("after_float", bus_data, FLOAT);
  endtask

  vec_t vecs[15];

  initial begin
    vec_t v;
    vecs[0]  = '{1'b0, 1'b1, 20'h105, 16'hBEEF, RDY,  16'h0};
    vecs[1]  = '{1'b1, 1'b0, 20'h105, 16'h0,    RDY,  16'hBEEF};
    vecs[2]  = '{1'b0, 1'b1, 20'h10F, 16'h5A5A, RDY,  16'h0};
    vecs[3]  = '{1'b1, 1'b0, 20'h10F, 16'h0,    RDY,  16'h5A5A};
    vecs[4]  = '{1'b1, 1'b0, 20'h0FF, 16'h0,    NONE, 16'h0};
    vecs[5]  = '{1'b1, 1'b0, 20'h110, 16'h0,    NONE, 16'h0};
    vecs[6]  = '{1'b0, 1'b1, 20'h110, 16'hAAAA, NONE, 16'h0};
    vecs[7]  = '{1'b0, 1'b1, 20'h100, 16'h0001, RDY,  16'h0};
    vecs[8]  = '{1'b1, 1'b0, 20'h100, 16'h0,    RDY,  16'h0001};
    vecs[9]  = '{1'b0, 1'b1, 20'h103, 16'h1111, RDY,  16'h0};
    vecs[10] = '{1'b0, 1'b1, 20'h108, 16'h7777, RDY,  16'h0};
    vecs[11] = '{1'b1, 1'b1, 20'h108, 16'h9999, ERR,  16'h0};
    vecs[12] = '{1'b1, 1'b0, 20'h108, 16'h0,    RDY,  16'h7777};
    vecs[13] = '{1'b0, 1'b1, 20'h10A, 16'h2222, RDY,  16'h0};
    vecs[14] = '{1'b1, 1'b0, 20'h103, 16'h0,    RDY,  16'h1111};

    rst_n    = 1'b0;
    bus_addr = '0;
    drv_data = '0;
    idle_bus();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", bus_ready, 0);
    chk("rst_err", bus_err, 0);
    chk("rst_float", bus_data, FLOAT);
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Abort: write withdrawn in the first BUSY cycle
    bus_addr = 20'h103;
    write    = 1'b1;
    drv_en   = 1'b1;
    drv_data = 16'h1234;
    @(posedge clk); #1;
    idle_bus();
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("abort_no_ready", bus_ready, 0);
    end
    v = '{1'b1, 1'b0, 20'h103, 16'h0, RDY, 16'h1111};
    run_vec(v);

    // Reset during BUSY of a write
    bus_addr = 20'h10A;
    write    = 1'b1;
    drv_en   = 1'b1;
    drv_data = 16'h3333;
    @(posedge clk); #1;
    rst_n = 1'b0;
    idle_bus();
    #1;
    chk("midrst_ready", bus_ready, 0);
    chk("midrst_err", bus_err, 0);
    chk("midrst_float", bus_data, FLOAT);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("postrst_ready", bus_ready, 0);
    end
    v = '{1'b1, 1'b0, 20'h10A, 16'h0, RDY, 16'h2222};
    run_vec(v);
    v = '{1'b0, 1'b1, 20'h10A, 16'h4444, RDY, 16'h0};
    run_vec(v);
    v = '{1'b1, 1'b0, 20'h10A, 16'h0, RDY, 16'h4444};
    run_vec(v);

`ifdef BUS_MEM_PARITY_EN
    v = '{1'b0, 1'b1, 20'h101, 16'h00FF, RDY, 16'h0};
    run_vec(v);
    dut.inject_parity_flip(20'h101);
    bus_addr = 20'h101;
    read     = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    idle_bus();
    #1;
    chk("par_ready", bus_ready, 1);
    chk("par_err", bus_err, 1);
    chk("par_data", bus_data, 16'h00FF);
    @(posedge clk); #1;
    chk("par_after", {bus_ready, bus_err}, 0);
`endif

    chk("sb_empty", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
